dht11_responder: RTL and testbench

DHT11_RESPONDER -- requirements
Module: dht11_responder

---
 rtl/dht11_pkg.sv | 40 ++++
 rtl/dht11_sync.sv | 33 +++
 rtl/dht11_responder.sv | 183 ++++++++++++++++++
 tb/tb_dht11_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 sensor emulator: state encoding,
// default timing constants (1 clk = 1 us) and a checksum helper.
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOST_LOW,
    WAIT,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_t;

  localparam int unsigned DEF_T_START_MIN = 18000;
  localparam int unsigned DEF_T_WAIT      = 30;
  localparam int unsigned DEF_T_RESP      = 80;
  localparam int unsigned DEF_T_BIT_LOW   = 50;
  localparam int unsigned DEF_T_ZERO_HIGH = 26;
  localparam int unsigned DEF_T_ONE_HIGH  = 70;

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned CNT_W      = 15;
  localparam int unsigned BIT_IDX_W  = 6;

  // Byte sum modulo 256, optionally inverted to inject a checksum error.
  function automatic logic [7:0] frame_checksum(
    input logic [7:0] humid_int,
    input logic [7:0] humid_dec,
    input logic [7:0] temp_int,
    input logic [7:0] temp_dec,
    input logic       invert
  );
    logic [7:0] sum;
    sum = humid_int + humid_dec + temp_int + temp_dec;
    return invert ? ~sum : sum;
  endfunction

endpackage

// File: rtl/dht11_sync.sv
// Two-flop synchronizer for the open-drain data line with edge pulses.
// Flops reset to 1 so a reset looks like a released (pulled-up) line.
module dht11_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic stable;
  logic prev;

  // Synchronize the raw line and keep one extra sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b1;
      stable <= 1'b1;
      prev   <= 1'b1;
    end else begin
      meta   <= raw;
      stable <= meta;
      prev   <= stable;
    end
  end

  assign level = stable;
  assign rise  = stable & ~prev;
  assign fall  = ~stable & prev;

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: waits for a host start pulse, then answers with
// the response preamble and a 40-bit frame (4 data bytes + checksum).
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int unsigned T_START_MIN = DEF_T_START_MIN,
  parameter int unsigned T_WAIT      = DEF_T_WAIT,
  parameter int unsigned T_RESP      = DEF_T_RESP,
  parameter int unsigned T_BIT_LOW   = DEF_T_BIT_LOW,
  parameter int unsigned T_ZERO_HIGH = DEF_T_ZERO_HIGH,
  parameter int unsigned T_ONE_HIGH  = DEF_T_ONE_HIGH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dq_in,
  output logic       dq_pull_low,
  input  logic [7:0] humid_int,
  input  logic [7:0] humid_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       corrupt_chk,
  output logic       busy,
  output logic       done
);

  // The IDLE cycle that sees the falling edge is already the first low
  // cycle, so a host low of N cycles leaves the counter at N-1 on release.
  localparam logic [CNT_W-1:0] START_SAT  = CNT_W'(T_START_MIN);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(T_START_MIN - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(T_WAIT - 1);
  localparam logic [CNT_W-1:0] RESP_LAST  = CNT_W'(T_RESP - 1);
  localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(T_BIT_LOW - 1);
  localparam logic [CNT_W-1:0] ZERO_LAST  = CNT_W'(T_ZERO_HIGH - 1);
  localparam logic [CNT_W-1:0] ONE_LAST   = CNT_W'(T_ONE_HIGH - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(FRAME_BITS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic [BIT_IDX_W-1:0]    bit_idx;
  logic [FRAME_BITS-1:0]   frame;
  logic                    load_frame;
  logic                    advance_bit;
  logic                    frame_end;
  logic                    line_level;
  logic                    line_rise;
  logic                    line_fall;
  logic [CNT_W-1:0]        high_last;

  dht11_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .raw   (dq_in),
    .level (line_level),
    .rise  (line_rise),
    .fall  (line_fall)
  );

  // State register; reset drops straight to IDLE so the line is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, counter and line-drive decode for every protocol phase.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    load_frame  = 1'b0;
    advance_bit = 1'b0;
    frame_end   = 1'b0;
    dq_pull_low = 1'b0;
    busy        = 1'b1;
    high_last   = frame[FRAME_BITS-1] ? ONE_LAST : ZERO_LAST;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (line_fall) begin
          state_next = HOST_LOW;
          cnt_next   = '0;
        end
      end
      HOST_LOW: begin
        busy = 1'b0;
        if (line_rise) begin
          cnt_next = '0;
          if (cnt >= START_LAST) begin
            state_next = WAIT;
            load_frame = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (!line_level && cnt != START_SAT) begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_next = RESP_LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RESP_LOW: begin
        dq_pull_low = 1'b1;
        if (cnt == RESP_LAST) begin
          state_next = RESP_HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RESP_HIGH: begin
        if (cnt == RESP_LAST) begin
          state_next = BIT_LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      BIT_LOW: begin
        dq_pull_low = 1'b1;
        if (cnt == LOW_LAST) begin
          state_next = BIT_HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      BIT_HIGH: begin
        if (cnt == high_last) begin
          advance_bit = 1'b1;
          cnt_next    = '0;
          state_next  = (bit_idx == LAST_BIT) ? END_LOW : BIT_LOW;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      END_LOW: begin
        dq_pull_low = 1'b1;
        if (cnt == LOW_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          frame_end  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Counter, latched frame shift register, bit index and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      frame   <= '0;
      done    <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      done <= frame_end;
      if (load_frame) begin
        frame   <= {humid_int, humid_dec, temp_int, temp_dec,
                    frame_checksum(humid_int, humid_dec, temp_int, temp_dec, corrupt_chk)};
        bit_idx <= '0;
      end else if (advance_bit) begin
        frame   <= {frame[FRAME_BITS-2:0], 1'b0};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Scoreboard bench for dht11_responder: a driver issues host start pulses
// and queues the expected frame; a monitor measures every low/released run
// of dq_pull_low, decodes the frame and compares it against the queue.
module tb_dht11_responder;

  localparam int T_START     = 1800;
  localparam int T_WAIT      = 30;
  localparam int T_RESP      = 80;
  localparam int T_BIT_LOW   = 50;
  localparam int T_ZERO_HIGH = 26;
  localparam int T_ONE_HIGH  = 70;
  // 2 synchronizer flops plus the edge-to-state register.
  localparam int IN_LATENCY  = 3;

  logic       clk;
  logic       rst;
  logic       dq_host_low;
  logic       dq_in;
  logic       dq_pull_low;
  logic [7:0] humid_int;
  logic [7:0] humid_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       corrupt_chk;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int release_cyc = 0;
  int frames_done = 0;
  int mon_bit = -1;
  logic aborted = 1'b0;
  logic [39:0] exp_q[$];

  assign dq_in = (dq_host_low || dq_pull_low) ? 1'b0 : 1'b1;

  dht11_responder #(
    .T_START_MIN (T_START)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dq_in       (dq_in),
    .dq_pull_low (dq_pull_low),
    .humid_int   (humid_int),
    .humid_dec   (humid_dec),
    .temp_int    (temp_int),
    .temp_dec    (temp_dec),
    .corrupt_chk (corrupt_chk),
    .busy        (busy),
    .done        (done)
  );

  // 1 MHz clock (1 us period) and a free-running cycle counter.
  initial begin
    clk = 1'b0;
    forever #500 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop if something never finishes.
  initial begin
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Length of the current run of dq_pull_low at the given level (negedge samples).
  task automatic measureRun(input logic lvl, output int len);
    len = 0;
    while (dq_pull_low === lvl && len < 5000) begin
      len++;
      @(negedge clk);
    end
  endtask

  // Host start pulse of n cycles on the bus, then release.
  task automatic hostStart(input int n);
    @(posedge clk);
    #1 dq_host_low = 1'b1;
    repeat (n) @(posedge clk);
    #1 dq_host_low = 1'b0;
    release_cyc = cyc;
  endtask

  task automatic applyStimulus(input logic [7:0] hi, input logic [7:0] hd, input logic [7:0] ti,
                               input logic [7:0] td, input logic corrupt, input logic [7:0] chk);
    humid_int   = hi;
    humid_dec   = hd;
    temp_int    = ti;
    temp_dec    = td;
    corrupt_chk = corrupt;
    exp_q.push_back({hi, hd, ti, td, chk});
    hostStart(T_START);
  endtask

  task automatic waitFrame(input int target);
    int t;
    t = 0;
    while (frames_done < target && t < 12000) begin
      @(posedge clk);
      t++;
    end
    checkOutput("frame_completed", frames_done, target);
  endtask

  task automatic waitBit(input int b);
    int t;
    t = 0;
    while (mon_bit != b && t < 12000) begin
      @(posedge clk);
      t++;
    end
    checkOutput("reached_bit", mon_bit, b);
  endtask

  // Short host pulse must be ignored: no drive and no busy at any time.
  task automatic rejectCheck(input int n, input string name);
    int act;
    act = 0;
    @(posedge clk);
    #1 dq_host_low = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 if (dq_pull_low || busy) act++;
    end
    dq_host_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1 if (dq_pull_low || busy) act++;
    end
    checkOutput(name, act, 0);
  endtask

  // Monitor: decode each frame from dq_pull_low and score it against the queue.
  initial begin : monitor
    int len;
    logic [39:0] got;
    logic [39:0] expf;
    forever begin
      @(negedge clk);
      if (dq_pull_low !== 1'b1) continue;
      checkOutput("frame_queued", exp_q.size() > 0, 1);
      if (exp_q.size() == 0) begin
        measureRun(1'b1, len);
        continue;
      end
      expf = exp_q.pop_front();
      got = '0;
      checkOutput("wait_gap", cyc - release_cyc, T_WAIT + IN_LATENCY);
      checkOutput("busy_in_frame", busy, 1);
      measureRun(1'b1, len);
      if (!aborted) begin
        checkOutput("resp_low", len, T_RESP);
        measureRun(1'b0, len);
      end
      if (!aborted) begin
        checkOutput("resp_high", len, T_RESP);
        for (int b = 0; b < 40; b++) begin
          mon_bit = b;
          measureRun(1'b1, len);
          if (aborted) break;
          checkOutput("bit_low", len, T_BIT_LOW);
          measureRun(1'b0, len);
          if (aborted) break;
          got = {got[38:0], (len > 48) ? 1'b1 : 1'b0};
          checkOutput("bit_high", len, expf[39-b] ? T_ONE_HIGH : T_ZERO_HIGH);
        end
      end
      if (aborted) begin
        aborted = 1'b0;
        mon_bit = -1;
        continue;
      end
      measureRun(1'b1, len);
      checkOutput("end_low", len, T_BIT_LOW);
      checkOutput("done_pulse", done, 1);
      checkOutput("busy_cleared", busy, 0);
      checkOutput("frame_data", got, expf);
      @(negedge clk);
      checkOutput("done_one_cycle", done, 0);
      mon_bit = -1;
      frames_done++;
    end
  end

  // Driver: directed scenarios with hand-computed checksums.
  initial begin : driver
    int t;
    rst = 1'b1;
    dq_host_low = 1'b0;
    humid_int = 8'h00;
    humid_dec = 8'h00;
    temp_int = 8'h00;
    temp_dec = 8'h00;
    corrupt_chk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_pull_low", dq_pull_low, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    $display("[TB] basic frame 37 00 19 00");
    applyStimulus(8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 8'h50);
    waitFrame(1);

    $display("[TB] short host pulses are ignored");
    rejectCheck(1000, "short_pulse_ignored");
    rejectCheck(T_START - 1, "one_short_ignored");

    $display("[TB] checksum wrap and corrupted checksum");
    applyStimulus(8'hFF, 8'hFF, 8'h02, 8'h03, 1'b0, 8'h03);
    waitFrame(2);
    applyStimulus(8'hFF, 8'hFF, 8'h02, 8'h03, 1'b1, 8'hFC);
    waitFrame(3);

    $display("[TB] reset in the middle of bit 20");
    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 8'h14);
    waitBit(20);
    aborted = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_mid_release", dq_pull_low, 0);
    checkOutput("reset_mid_busy", busy, 0);
    rst = 1'b0;
    t = 0;
    while (aborted && t < 200) begin
      @(posedge clk);
      t++;
    end
    checkOutput("abort_seen", aborted, 0);
    applyStimulus(8'hAA, 8'h55, 8'h0F, 8'hF0, 1'b0, 8'hFE);
    waitFrame(4);

    $display("[TB] input changes and line glitch during bit 10");
    applyStimulus(8'h01, 8'h20, 8'h05, 8'h0A, 1'b0, 8'h30);
    waitBit(10);
    repeat (55) @(posedge clk);
    #1;
    dq_host_low = 1'b1;
    humid_int = 8'hEE;
    humid_dec = 8'hDD;
    temp_int = 8'hCC;
    temp_dec = 8'hBB;
    corrupt_chk = 1'b1;
    repeat (5) @(posedge clk);
    #1 dq_host_low = 1'b0;
    waitFrame(5);

    repeat (10) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
